fifo_umbral: RTL and testbench
==============================

// Module: fifo_umbral
// PURPOSE
//   Synchronous FIFO with programmable high/low occupancy thresholds.
//   One instance per Main, VC and D queue, directly downstream of the control state machine.
//   It consumes that machine's latched thresholds (Umbral_*_alto/bajo_interno).
//   It returns the status the machine consumes: one bit each of FIFO_empties and FIFO_errors, plus pause flags.
// PARAMETERS
//   DATA_W  6  payload width in bits
//   ADDR_W  2  address width; DEPTH = 2**ADDR_W entries (default 4)
//   UMB_W   5  threshold/count width; must satisfy 2**UMB_W > DEPTH
// PORTS
//   clk           in   1       single clock, all logic on posedge
//   reset         in   1       asynchronous, active-high; clears all state
//   wr_en         in   1       push request
//   data_in       in   DATA_W  push data
//   rd_en         in   1       pop request
//   data_out      out  DATA_W  pop data, registered
//   valid_out     out  1       data_out holds a popped word this cycle
//   umbral_alto   in   UMB_W   almost-full threshold, from state machine
//   umbral_bajo   in   UMB_W   almost-empty threshold, from state machine
//   count         out  UMB_W   current occupancy, 0..DEPTH
//   full          out  1       count == DEPTH
//   empty         out  1       count == 0; drives FIFO_empties bit
//   almost_full   out  1       count >= umbral_alto
//   almost_empty  out  1       count <= umbral_bajo
//   error         out  1       sticky overflow/underflow; drives FIFO_errors bit
// BEHAVIOUR
//   Reset, applied asynchronously:
//     wr_ptr=rd_ptr=0, count=0, data_out=0, valid_out=0, error=0.
//     Hence empty=1, full=0, almost_full=(umbral_alto==0), almost_empty=1.
//   Accepted push (wr_en & ~full, or wr_en & full & rd_en):
//     mem[wr_ptr] <= data_in; wr_ptr increments and wraps modulo DEPTH.
//   Accepted pop (rd_en & ~empty):
//     data_out <= mem[rd_ptr] and valid_out <= 1 on the next edge (latency 1).
//     rd_ptr increments and wraps modulo DEPTH.
//     When there is no accepted pop, valid_out <= 0 and data_out holds its value.
//   Count: +1 on push only, -1 on pop only, unchanged on both or neither.
//   Full with wr_en & rd_en: both accepted; count stays DEPTH; the read is of the old word.
//   Empty with wr_en & rd_en: write accepted; the read is an underflow; no bypass.
//   Overflow: wr_en & full & ~rd_en. Word dropped; pointers unchanged; error <= 1.
//   Underflow: rd_en & empty. No pop; valid_out <= 0; error <= 1.
//   error is sticky until reset (see CONFIGURATION).
//   full, empty, almost_full and almost_empty are combinational from registered count and the threshold inputs.
//   Thresholds are not latched here. A change takes effect on the flags in the same cycle.
//   Threshold boundaries:
//     umbral_alto > DEPTH    -> almost_full never asserts.
//     umbral_alto == 0       -> almost_full always 1.
//     umbral_bajo >= DEPTH   -> almost_empty always 1.
//   Compares are unsigned, UMB_W wide.
//   Reset mid-operation: contents are discarded, not cleared; pointers and flags return to reset values immediately.
// CONFIGURATION
//   FIFO_ERR_CLEAR_EN defined:
//     Adds input err_clr (1 bit).
//     err_clr=1 clears error on the next edge, unless a new overflow/underflow occurs in that same cycle; set wins.
//   FIFO_ERR_CLEAR_EN undefined:
//     No err_clr port; error clears only by reset.
// STRUCTURE
//   Shared header fifo_defs.vh:
//     Default DATA_W, ADDR_W and UMB_W values.
//     Localparam DEPTH.
//     Queue index constants MF=0, VC=1, D=2 for bit positions in FIFO_empties/FIFO_errors.
//   Sub-module fifo_mem:
//     DEPTH x DATA_W register array, one write port, one registered read port; no reset on storage.
//   fifo_umbral contains pointers, count, flag logic and error logic only.
// TESTING
//   1 Reset: assert reset mid-clock with no edge -> count=0, empty=1, error=0, valid_out=0 immediately.
//   2 Fill/drain with umbral_alto=3, umbral_bajo=1:
//     Push 0x11,0x22,0x33,0x04 -> almost_full rises after the 3rd push, full=1 after the 4th.
//     Pop 4 -> data_out 0x11,0x22,0x33,0x04 each one cycle after rd_en; empty=1 at end.
//   3 Overflow: FIFO full, push 0x3F without rd_en -> error=1, count=4, and 0x3F is never read out.
//   4 Underflow: FIFO empty, rd_en=1 -> error=1, valid_out=0.
//     With FIFO_ERR_CLEAR_EN, err_clr=1 for 1 cycle -> error=0.
//   5 Simultaneous push and pop:
//     Full with wr_en&rd_en -> count stays 4, head popped, new word at tail.
//     Empty with wr_en&rd_en -> count=1, error=1.
//   6 Wrap and live thresholds:
//     10 interleaved push/pop pairs -> pointer wrap, order preserved.
//     Change umbral_alto 3->1 at count=2 -> almost_full=1 the same cycle.
//     Then umbral_alto=31 -> almost_full=0.

Source files
------------

// File: rtl/fifo_umbral_pkg.sv
// rtl/fifo_umbral_pkg.sv - shared defaults and queue indices for fifo_umbral
package fifo_umbral_pkg;

  // Default geometry; UMB_W must hold DEPTH, so 2**UMB_W > DEPTH
  localparam int DATA_W_DEF = 6;
  localparam int ADDR_W_DEF = 2;
  localparam int UMB_W_DEF  = 5;
  localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

  // Bit positions of each queue in FIFO_empties / FIFO_errors
  localparam int MF = 0;
  localparam int VC = 1;
  localparam int D  = 2;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W storage with one write port and a registered read port
module fifo_mem
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Storage is never reset: stale words are unreachable once the pointers clear
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Read register holds its value between pops; a write to the same slot
  // on the same edge is not seen (old word is read)
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_rd_data <= '0;
    else if (rd_en) r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - threshold FIFO; FIFO_ERR_CLEAR_EN adds the err_clr input
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int UMB_W  = UMB_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic [UMB_W-1:0]  umbral_alto,
  input  logic [UMB_W-1:0]  umbral_bajo,
`ifdef FIFO_ERR_CLEAR_EN
  input  logic              err_clr,
`endif
  output logic [UMB_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error
);

  localparam int               DEPTH   = 1 << ADDR_W;
  localparam logic [UMB_W-1:0] DEPTH_C = UMB_W'(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [UMB_W-1:0]  r_count;
  logic              r_valid;
  logic              r_error;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_ovf;
  logic w_unf;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // A full FIFO still accepts a push when a pop frees the head slot;
  // an empty FIFO never bypasses the pushed word to the read side.
  assign w_push = wr_en & (~w_full | rd_en);
  assign w_pop  = rd_en & ~w_empty;
  assign w_ovf  = wr_en & w_full & ~rd_en;
  assign w_unf  = rd_en & w_empty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_push),
    .wr_addr (r_wr_ptr),
    .wr_data (data_in),
    .rd_en   (w_pop),
    .rd_addr (r_rd_ptr),
    .rd_data (data_out)
  );

  // Pointers wrap naturally at DEPTH because they are exactly ADDR_W wide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy moves only when exactly one of push/pop is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + UMB_W'(1);
        2'b01:   r_count <= r_count - UMB_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // valid_out marks the cycle after an accepted pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_valid <= 1'b0;
    else       r_valid <= w_pop;
  end

  // Sticky error; a new fault in the clearing cycle keeps it set
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_error <= 1'b0;
    else if (w_ovf | w_unf)  r_error <= 1'b1;
`ifdef FIFO_ERR_CLEAR_EN
    else if (err_clr)        r_error <= 1'b0;
`endif
  end

  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= umbral_alto);
  assign almost_empty = (r_count <= umbral_bajo);
  assign valid_out    = r_valid;
  assign error        = r_error;

endmodule

// File: tb/tb_fifo_umbral.sv
// tb/tb_fifo_umbral.sv - directed self-checking bench for fifo_umbral
module tb_fifo_umbral;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [5:0] data_in;
  logic       rd_en;
  logic [5:0] data_out;
  logic       valid_out;
  logic [4:0] umbral_alto;
  logic [4:0] umbral_bajo;
`ifdef FIFO_ERR_CLEAR_EN
  logic       err_clr;
`endif
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       error;

  int n_checks = 0;
  int n_errors = 0;

  fifo_umbral dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
`ifdef FIFO_ERR_CLEAR_EN
    .err_clr      (err_clr),
`endif
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int c, input bit e, input bit f,
                        input bit af, input bit ae, input bit er);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
    chk({tag, ".error"}, 32'(error), 32'(er));
  endtask

  task automatic chk_rd(input string tag, input bit v, input logic [5:0] d);
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(v));
    chk({tag, ".data_out"}, 32'(data_out), 32'(d));
  endtask

  // Advance one edge; inputs then change and outputs are sampled 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] d);
    wr_en = 1'b1; rd_en = 1'b0; data_in = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    umbral_alto = 5'd3; umbral_bajo = 5'd1;
`ifdef FIFO_ERR_CLEAR_EN
    err_clr = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;

    // 1 Reset: build non-reset state, then assert reset between edges
    chk_st("rst_init", 0, 1, 0, 0, 1, 0);
    pop();
    chk("pre_unf.error", 32'(error), 32'd1);
    push(6'h2A);
    push(6'h2B);
    pop();
    chk_rd("pre_pop", 1, 6'h2A);
    chk("pre_pop.count", 32'(count), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_st("async_rst", 0, 1, 0, 0, 1, 0);
    chk_rd("async_rst", 0, 6'h00);
    tick();
    reset = 1'b0;

    // 2 Fill/drain with alto=3, bajo=1
    push(6'h11); chk_st("fill1", 1, 0, 0, 0, 1, 0);
    push(6'h22); chk_st("fill2", 2, 0, 0, 0, 0, 0);
    push(6'h33); chk_st("fill3", 3, 0, 0, 1, 0, 0);
    push(6'h04); chk_st("fill4", 4, 0, 1, 1, 0, 0);
    pop(); chk_rd("drain1", 1, 6'h11); chk_st("drain1", 3, 0, 0, 1, 0, 0);
    pop(); chk_rd("drain2", 1, 6'h22); chk_st("drain2", 2, 0, 0, 0, 0, 0);
    pop(); chk_rd("drain3", 1, 6'h33); chk_st("drain3", 1, 0, 0, 0, 1, 0);
    pop(); chk_rd("drain4", 1, 6'h04); chk_st("drain4", 0, 1, 0, 0, 1, 0);
    tick(); chk_rd("idle_hold", 0, 6'h04);

    // 3 Overflow drops the word and sets error
    push(6'h01); push(6'h02); push(6'h03); push(6'h05);
    push(6'h3F);
    chk_st("ovf", 4, 0, 1, 1, 0, 1);
    pop(); chk_rd("ovf_rd1", 1, 6'h01);
    pop(); chk_rd("ovf_rd2", 1, 6'h02);
    pop(); chk_rd("ovf_rd3", 1, 6'h03);
    pop(); chk_rd("ovf_rd4", 1, 6'h05);
    chk_st("ovf_drained", 0, 1, 0, 0, 1, 1);
    pop(); chk_rd("ovf_unf", 0, 6'h05);
    do_reset();

    // 4 Underflow
    pop();
    chk_rd("unf", 0, 6'h00);
    chk_st("unf", 0, 1, 0, 0, 1, 1);
`ifdef FIFO_ERR_CLEAR_EN
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr.error", 32'(error), 32'd0);
    err_clr = 1'b1; rd_en = 1'b1; tick(); err_clr = 1'b0; rd_en = 1'b0;
    chk("set_wins.error", 32'(error), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr2.error", 32'(error), 32'd0);
`else
    tick();
    chk("sticky.error", 32'(error), 32'd1);
`endif
    do_reset();

    // 5 Simultaneous push and pop
    push(6'h0A); push(6'h0B); push(6'h0C); push(6'h0D);
    wr_en = 1'b1; rd_en = 1'b1; data_in = 6'h0E;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk_rd("full_rw", 1, 6'h0A);
    chk_st("full_rw", 4, 0, 1, 1, 0, 0);
    pop(); chk_rd("full_rw_rd1", 1, 6'h0B);
    pop(); chk_rd("full_rw_rd2", 1, 6'h0C);
    pop(); chk_rd("full_rw_rd3", 1, 6'h0D);
    pop(); chk_rd("full_rw_rd4", 1, 6'h0E);
    wr_en = 1'b1; rd_en = 1'b1; data_in = 6'h15;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk_rd("empty_rw", 0, 6'h0E);
    chk_st("empty_rw", 1, 0, 0, 0, 1, 1);
    pop(); chk_rd("empty_rw_rd", 1, 6'h15);
    do_reset();

    // 6 Wrap with interleaved pairs, then live thresholds
    for (int i = 0; i < 10; i++) begin
      push(6'(8'h20 + i));
      pop();
      chk_rd($sformatf("wrap%0d", i), 1, 6'(8'h20 + i));
    end
    chk_st("wrap_end", 0, 1, 0, 0, 1, 0);
    push(6'h31); push(6'h32);
    chk("live.af_alto3", 32'(almost_full), 32'd0);
    umbral_alto = 5'd1; #1;
    chk("live.af_alto1", 32'(almost_full), 32'd1);
    umbral_alto = 5'd31; #1;
    chk("live.af_alto31", 32'(almost_full), 32'd0);
    umbral_alto = 5'd0; #1;
    chk("live.af_alto0", 32'(almost_full), 32'd1);
    umbral_bajo = 5'd4; #1;
    chk("live.ae_bajo4", 32'(almost_empty), 32'd1);
    umbral_bajo = 5'd2; #1;
    chk("live.ae_bajo2", 32'(almost_empty), 32'd1);
    umbral_bajo = 5'd1; #1;
    chk("live.ae_bajo1", 32'(almost_empty), 32'd0);
    umbral_alto = 5'd5;
    push(6'h33); push(6'h34);
    chk_st("alto5_full", 4, 0, 1, 0, 0, 0);
    pop(); chk_rd("wrap_tail1", 1, 6'h31);
    pop(); chk_rd("wrap_tail2", 1, 6'h32);
    pop(); chk_rd("wrap_tail3", 1, 6'h33);
    pop(); chk_rd("wrap_tail4", 1, 6'h34);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
